// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake and a forwarding tap.
// Define EX_MEM_SKID_EN to add a skid entry that gives a registered ready_o.
module ex_mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] result_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [2:0]            ctrl_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [DATA_WIDTH-1:0] store_data_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [2:0]            ctrl_o,
    output logic                  fwd_en_o,
    output logic [REG_ADDR_W-1:0] fwd_rd_o,
    output logic [DATA_WIDTH-1:0] fwd_data_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [DATA_WIDTH-1:0] store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            ctrl;
    } entry_t;

    entry_t in_entry_s;
    entry_t out_r;
    entry_t out_nxt_s;
    logic   out_valid_r;
    logic   out_valid_nxt_s;
    logic   out_free_s;
    logic   accept_s;

    // Writes to x0 are architecturally dropped, so reg_write is cleared on capture.
    assign in_entry_s.result     = result_i;
    assign in_entry_s.store_data = store_data_i;
    assign in_entry_s.rd         = rd_i;
    assign in_entry_s.ctrl       = {ctrl_i[2] & (rd_i != {REG_ADDR_W{1'b0}}), ctrl_i[1:0]};

    assign out_free_s = ~out_valid_r | ready_i;

`ifdef EX_MEM_SKID_EN
    entry_t sk_r;
    entry_t sk_nxt_s;
    logic   sk_valid_r;
    logic   sk_valid_nxt_s;

    assign ready_o  = ~sk_valid_r;
    assign accept_s = valid_i & ~sk_valid_r & ~flush_i;

    // Next-state for OUT and SK; SK only fills while OUT is held by a stall.
    always_comb begin
        out_nxt_s       = out_r;
        out_valid_nxt_s = out_valid_r;
        sk_nxt_s        = sk_r;
        sk_valid_nxt_s  = sk_valid_r;
        if (flush_i) begin
            out_valid_nxt_s = 1'b0;
            sk_valid_nxt_s  = 1'b0;
        end else if (out_free_s) begin
            if (sk_valid_r) begin
                out_nxt_s       = sk_r;
                out_valid_nxt_s = 1'b1;
                sk_valid_nxt_s  = 1'b0;
            end else if (accept_s) begin
                out_nxt_s       = in_entry_s;
                out_valid_nxt_s = 1'b1;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else if (accept_s) begin
            sk_nxt_s       = in_entry_s;
            sk_valid_nxt_s = 1'b1;
        end else begin
            sk_valid_nxt_s = sk_valid_r;
        end
    end

    // Skid register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sk_r       <= '0;
            sk_valid_r <= 1'b0;
        end else begin
            sk_r       <= sk_nxt_s;
            sk_valid_r <= sk_valid_nxt_s;
        end
    end
`else
    assign ready_o  = out_free_s;
    assign accept_s = valid_i & out_free_s & ~flush_i;

    // Next-state for the single OUT entry.
    always_comb begin
        out_nxt_s       = out_r;
        out_valid_nxt_s = out_valid_r;
        if (flush_i) begin
            out_valid_nxt_s = 1'b0;
        end else if (accept_s) begin
            out_nxt_s       = in_entry_s;
            out_valid_nxt_s = 1'b1;
        end else if (ready_i) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end
`endif

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_r       <= out_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    assign valid_o      = out_valid_r;
    assign result_o     = out_r.result;
    assign store_data_o = out_r.store_data;
    assign rd_o         = out_r.rd;
    assign ctrl_o       = out_r.ctrl;
    assign fwd_en_o     = out_valid_r & out_r.ctrl[2];
    assign fwd_rd_o     = out_r.rd;
    assign fwd_data_o   = out_r.result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed vector table, corner-case sequences and a queue scoreboard for ex_mem_stage.
module tb_ex_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i, valid_i, ready_o, valid_o, ready_i, fwd_en_o;
    logic [31:0] result_i, store_data_i, result_o, store_data_o, fwd_data_o;
    logic [4:0]  rd_i, rd_o, fwd_rd_o;
    logic [2:0]  ctrl_i, ctrl_o;

    int total = 0;
    int bad   = 0;

    ex_mem_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .result_i(result_i), .store_data_i(store_data_i), .rd_i(rd_i), .ctrl_i(ctrl_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .store_data_o(store_data_o),
        .rd_o(rd_o), .ctrl_o(ctrl_o), .fwd_en_o(fwd_en_o), .fwd_rd_o(fwd_rd_o),
        .fwd_data_o(fwd_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic rdy, input logic [31:0] res,
                         input logic [31:0] sd, input logic [4:0] rd, input logic [2:0] ctrl);
        valid_i = v; flush_i = fl; ready_i = rdy; result_i = res;
        store_data_i = sd; rd_i = rd; ctrl_i = ctrl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v, fl;
        logic [31:0] res, sd;
        logic [4:0]  rd;
        logic [2:0]  ctrl;
        logic        e_v, e_fwd;
        logic [31:0] e_res, e_sd;
        logic [4:0]  e_rd;
        logic [2:0]  e_ctrl;
    } vec_t;

    vec_t vecs[7];
    logic [31:0] q[$];
    logic [31:0] exp_res, prev_res;
    logic        acc, prev_stall;
    logic [31:0] seq_no;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0000_0011, 5'd5,  3'b100, 1'b1, 1'b1, 32'h0000_1234, 32'h0000_0011, 5'd5,  3'b100};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_ABCD, 32'h0000_0055, 5'd0,  3'b100, 1'b1, 1'b0, 32'h0000_ABCD, 32'h0000_0055, 5'd0,  3'b000};
        vecs[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 5'd31, 3'b010, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 5'd31, 3'b010};
        vecs[3] = '{1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 5'd3,  3'b100, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 5'd31, 3'b010};
        vecs[4] = '{1'b1, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd1,  3'b101, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd1,  3'b101};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 5'd2,  3'b100, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd1,  3'b101};
        vecs[6] = '{1'b1, 1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 5'd16, 3'b001, 1'b1, 1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 5'd16, 3'b001};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 3'b000);
        step(); step();
        chk("rst_valid_o", valid_o, 1'b0);
        chk("rst_result_o", result_o, 32'h0);
        chk("rst_ctrl_o", ctrl_o, 3'b000);
        chk("rst_fwd_en", fwd_en_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready_o", ready_o, 1'b1);

        // Table: ready_i held high, each entry appears one cycle after acceptance
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v, vecs[i].fl, 1'b1, vecs[i].res, vecs[i].sd, vecs[i].rd, vecs[i].ctrl);
            step();
            chk($sformatf("vec%0d_valid_o", i), valid_o, vecs[i].e_v);
            chk($sformatf("vec%0d_result_o", i), result_o, vecs[i].e_res);
            chk($sformatf("vec%0d_store_data_o", i), store_data_o, vecs[i].e_sd);
            chk($sformatf("vec%0d_rd_o", i), rd_o, vecs[i].e_rd);
            chk($sformatf("vec%0d_ctrl_o", i), ctrl_o, vecs[i].e_ctrl);
            chk($sformatf("vec%0d_fwd_en", i), fwd_en_o, vecs[i].e_fwd);
            chk($sformatf("vec%0d_fwd_rd", i), fwd_rd_o, vecs[i].e_rd);
            chk($sformatf("vec%0d_fwd_data", i), fwd_data_o, vecs[i].e_res);
        end

        // Back-pressure: push A=1, B=2 into a stalled stage, then release
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 3'b000);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'd1, 32'h0, 5'd7, 3'b100);
        step();
        chk("stall_a_valid", valid_o, 1'b1);
        chk("stall_a_result", result_o, 32'd1);
`ifdef EX_MEM_SKID_EN
        chk("stall_a_ready", ready_o, 1'b1);
`else
        chk("stall_a_ready", ready_o, 1'b0);
`endif
        drive(1'b1, 1'b0, 1'b0, 32'd2, 32'h0, 5'd8, 3'b100);
        step();
        chk("stall_b_ready", ready_o, 1'b0);
        chk("stall_b_result_held", result_o, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'd9, 32'h0, 5'd9, 3'b100);
        step();
        chk("stall_hold_valid", valid_o, 1'b1);
        chk("stall_hold_result", result_o, 32'd1);
        chk("stall_hold_rd", rd_o, 5'd7);
        ready_i = 1'b1;
        step();
`ifdef EX_MEM_SKID_EN
        chk("drain_b_valid", valid_o, 1'b1);
        chk("drain_b_result", result_o, 32'd2);
        chk("drain_b_rd", rd_o, 5'd8);
`else
        chk("drain_b_valid", valid_o, 1'b0);
`endif
        chk("drain_ready", ready_o, 1'b1);
        step();
        chk("drain_empty", valid_o, 1'b0);

        // Flush with both entries occupied, alongside valid_i and ready_i
        drive(1'b1, 1'b0, 1'b0, 32'd3, 32'h0, 5'd3, 3'b100);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'd4, 32'h0, 5'd4, 3'b100);
        step();
        drive(1'b1, 1'b1, 1'b1, 32'd5, 32'h0, 5'd5, 3'b100);
        step();
        chk("flush_valid_o", valid_o, 1'b0);
        chk("flush_ready_o", ready_o, 1'b1);
        chk("flush_fwd_en", fwd_en_o, 1'b0);
        chk("flush_payload_kept", result_o, 32'd3);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 3'b000);
        step();
        chk("flush_nothing_delivered", valid_o, 1'b0);

        // Asynchronous reset while an entry is stalled
        drive(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd6, 3'b100);
        step();
        valid_i = 1'b0;
        chk("pre_arst_valid", valid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_o", valid_o, 1'b0);
        chk("arst_result_o", result_o, 32'h0);
        chk("arst_fwd_en", fwd_en_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_release_ready", ready_o, 1'b1);
        chk("arst_release_valid", valid_o, 1'b0);

        // Random handshake against an in-order scoreboard
        seq_no = 32'd100;
        prev_stall = 1'b0;
        prev_res = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), seq_no,
                  32'h0, 5'd1, 3'b100);
            #1;
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    chk("rand_spurious_release", 1'b1, 1'b0);
                end else begin
                    exp_res = q.pop_front();
                    chk("rand_order", result_o, exp_res);
                end
            end
            acc = valid_i && ready_o;
            if (acc) begin
                q.push_back(seq_no);
                seq_no = seq_no + 32'd1;
            end
            prev_stall = valid_o && !ready_i;
            prev_res   = result_o;
            step();
            if (prev_stall) begin
                chk("rand_stall_valid", valid_o, 1'b1);
                chk("rand_stall_result", result_o, prev_res);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 3'b000);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (valid_o) begin
                if (q.size() == 0) begin
                    chk("drain_spurious_release", 1'b1, 1'b0);
                end else begin
                    exp_res = q.pop_front();
                    chk("drain_order", result_o, exp_res);
                end
            end
            step();
        end
        chk("scoreboard_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
